// File: rtl/ssd_driver.sv
// Registered hex-to-seven-segment decoder with blanking and selectable output polarity.
// Q_out bit order is {g,f,e,d,c,b,a}; the off pattern depends on ACTIVE_LOW.
module ssd_driver #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       blank,
  input  logic [3:0] Q_in,
  output logic [6:0] Q_out
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [6:0] seg_active_low;
  logic [6:0] q_out_d;
  logic [6:0] q_out_q;

  // Patterns are held in active-low form; unmatched (X/Z) codes fall to all-off.
  always_comb begin
    seg_active_low = 7'b1111111;
    case (Q_in)
      4'h0:    seg_active_low = 7'b1000000;
      4'h1:    seg_active_low = 7'b1111001;
      4'h2:    seg_active_low = 7'b0100100;
      4'h3:    seg_active_low = 7'b0110000;
      4'h4:    seg_active_low = 7'b0011001;
      4'h5:    seg_active_low = 7'b0010010;
      4'h6:    seg_active_low = 7'b0000010;
      4'h7:    seg_active_low = 7'b1111000;
      4'h8:    seg_active_low = 7'b0000000;
      4'h9:    seg_active_low = 7'b0010000;
      4'hA:    seg_active_low = 7'b0001000;
      4'hB:    seg_active_low = 7'b0000011;
      4'hC:    seg_active_low = 7'b1000110;
      4'hD:    seg_active_low = 7'b0100001;
      4'hE:    seg_active_low = 7'b0000110;
      4'hF:    seg_active_low = 7'b0001110;
      default: seg_active_low = 7'b1111111;
    endcase
  end

  always_comb begin
    q_out_d = ACTIVE_LOW ? seg_active_low : ~seg_active_low;
    if (blank) begin
      q_out_d = SEG_OFF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_out_q <= SEG_OFF;
    end else begin
      q_out_q <= q_out_d;
    end
  end

  assign Q_out = q_out_q;

endmodule

// File: tb/tb_ssd_driver.sv
// Self-checking bench for ssd_driver: both polarities side by side, table-driven
// vectors through a scoreboard queue plus hand-written reset and X-input sequences.
module tb_ssd_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       blank;
  logic [3:0] q_in;
  logic [6:0] q_out_al;
  logic [6:0] q_out_ah;

  always #5 clock = ~clock;

  ssd_driver #(.ACTIVE_LOW(1'b1)) dut_al (
    .clock   (clock),
    .reset_n (reset_n),
    .blank   (blank),
    .Q_in    (q_in),
    .Q_out   (q_out_al)
  );

  ssd_driver #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clock   (clock),
    .reset_n (reset_n),
    .blank   (blank),
    .Q_in    (q_in),
    .Q_out   (q_out_ah)
  );

  typedef struct {
    logic [3:0] q;
    logic       b;
    logic [6:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [6:0] exp_al;
    logic [6:0] exp_ah;
    string      name;
  } sb_t;

  localparam int NUM_VECS = 22;

  vec_t       vecs [NUM_VECS];
  sb_t        sb_q [$];
  int         tests = 0;
  int         fails = 0;
  logic [6:0] last_al;
  logic [6:0] last_ah;

  task automatic compare(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive on the falling edge, queue the expected result for the next rising edge,
  // and confirm the output has not moved before that edge.
  task automatic applyStimulus(input logic [3:0] q, input logic b, input logic [6:0] exp_al,
                               input string name);
    sb_t e;
    @(negedge clock);
    q_in  = q;
    blank = b;
    e.exp_al = exp_al;
    e.exp_ah = ~exp_al;
    e.name   = name;
    sb_q.push_back(e);
    #1;
    compare({name, "_hold_al"}, q_out_al, last_al);
    compare({name, "_hold_ah"}, q_out_ah, last_ah);
  endtask

  task automatic checkOutput();
    sb_t e;
    @(posedge clock);
    #1;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end else begin
      tests--;
      e = sb_q.pop_front();
      compare({e.name, "_al"}, q_out_al, e.exp_al);
      compare({e.name, "_ah"}, q_out_ah, e.exp_ah);
      last_al = e.exp_al;
      last_ah = e.exp_ah;
    end
  endtask

  initial begin
    sb_t e;

    vecs[0]  = '{4'h0, 1'b0, 7'b1000000, "hex0"};
    vecs[1]  = '{4'h1, 1'b0, 7'b1111001, "hex1"};
    vecs[2]  = '{4'h2, 1'b0, 7'b0100100, "hex2"};
    vecs[3]  = '{4'h3, 1'b0, 7'b0110000, "hex3"};
    vecs[4]  = '{4'h4, 1'b0, 7'b0011001, "hex4"};
    vecs[5]  = '{4'h5, 1'b0, 7'b0010010, "hex5"};
    vecs[6]  = '{4'h6, 1'b0, 7'b0000010, "hex6"};
    vecs[7]  = '{4'h7, 1'b0, 7'b1111000, "hex7"};
    vecs[8]  = '{4'h8, 1'b0, 7'b0000000, "hex8"};
    vecs[9]  = '{4'h9, 1'b0, 7'b0010000, "hex9"};
    vecs[10] = '{4'hA, 1'b0, 7'b0001000, "hexA"};
    vecs[11] = '{4'hB, 1'b0, 7'b0000011, "hexB"};
    vecs[12] = '{4'hC, 1'b0, 7'b1000110, "hexC"};
    vecs[13] = '{4'hD, 1'b0, 7'b0100001, "hexD"};
    vecs[14] = '{4'hE, 1'b0, 7'b0000110, "hexE"};
    vecs[15] = '{4'hF, 1'b0, 7'b0001110, "hexF"};
    vecs[16] = '{4'h3, 1'b1, 7'b1111111, "blank3"};
    vecs[17] = '{4'h3, 1'b0, 7'b0110000, "unblank3"};
    vecs[18] = '{4'hA, 1'b1, 7'b1111111, "blank_change_A"};
    vecs[19] = '{4'h1, 1'b0, 7'b1111001, "unblank1"};
    vecs[20] = '{4'h8, 1'b1, 7'b1111111, "blank8"};
    vecs[21] = '{4'hF, 1'b0, 7'b0001110, "unblankF"};

    reset_n = 1'b1;
    blank   = 1'b0;
    q_in    = 4'h8;
    #1 reset_n = 1'b0;
    #1;
    compare("reset_pre_edge_al", q_out_al, 7'b1111111);
    compare("reset_pre_edge_ah", q_out_ah, 7'b0000000);
    repeat (2) @(posedge clock);
    #1;
    compare("reset_held_al", q_out_al, 7'b1111111);
    compare("reset_held_ah", q_out_ah, 7'b0000000);

    // First edge after release loads the decode of the waiting input (0x8).
    @(negedge clock);
    reset_n  = 1'b1;
    e.exp_al = 7'b0000000;
    e.exp_ah = 7'b1111111;
    e.name   = "release_hex8";
    sb_q.push_back(e);
    checkOutput();

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].q, vecs[i].b, vecs[i].exp, vecs[i].name);
      checkOutput();
    end

    // Asynchronous reset between edges, then release with Q_in still at 0x2.
    applyStimulus(4'h2, 1'b0, 7'b0100100, "pre_reset_hex2");
    checkOutput();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    compare("async_reset_al", q_out_al, 7'b1111111);
    compare("async_reset_ah", q_out_ah, 7'b0000000);
    @(posedge clock);
    #1;
    compare("reset_over_edge_al", q_out_al, 7'b1111111);
    compare("reset_over_edge_ah", q_out_ah, 7'b0000000);
    @(negedge clock);
    reset_n  = 1'b1;
    e.exp_al = 7'b0100100;
    e.exp_ah = 7'b1011011;
    e.name   = "release_hex2";
    sb_q.push_back(e);
    checkOutput();

    // Unknown input code must never leak X onto the segment lines.
    @(negedge clock);
    q_in  = 4'bxxxx;
    blank = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if ($isunknown(q_out_al) || $isunknown(q_out_ah)) begin
      fails++;
      $display("[TB] FAIL x_input: got %b / %b, expected no X/Z bits", q_out_al, q_out_ah);
    end

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_driver.md
# ssd_driver

Registered hexadecimal-to-seven-segment decoder driving the cathode lines of the 4-digit seven-segment display. It sits downstream of the display multiplexer (`SSD_Display`), which selects one nibble of a 16-bit value per digit slot and presents it on `Q_in`. The block converts that nibble into a segment pattern on `Q_out`, registered on the system clock. It also provides blanking and a configurable output polarity.

## Interface
- `ACTIVE_LOW`, default 1: segment polarity. 1 means a segment is lit when its bit is 0 (common-anode board). 0 inverts every output bit.
- `clock`  input  1  system clock (100 MHz board clock); all state updates on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `blank`  input  1  active-high; forces all segments off.
- `Q_in`  input  4  hex digit to display, 0x0–0xF.
- `Q_out`  output  7  segment drive, bit order {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a).

## Operation
- Decode table, ACTIVE_LOW=1, `Q_in` → `Q_out` (binary, g..a):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000.
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000.
  - 8→0000000, 9→0010000, A→0001000, b→0000011.
  - C→1000110, d→0100001, E→0000110, F→0001110.
- The "off" pattern is 1111111 for ACTIVE_LOW=1 and 0000000 for ACTIVE_LOW=0.
- When ACTIVE_LOW=0, each decoded pattern is the bitwise inverse of the table entry.
- `blank`=1 selects the off pattern regardless of `Q_in`.
- Any X/Z or otherwise unmatched `Q_in` value (default branch) selects the off pattern. The output never goes X.
- The decode is combinational into a single 7-bit output register. No other state.

## Timing
- Reset: while `reset_n`=0, `Q_out` is the off pattern. Reset asserts asynchronously, without waiting for a clock edge.
- Reset release: the first rising `clock` with `reset_n`=1 loads the decode of the current `Q_in`/`blank`.
- Latency: exactly 1 clock. `Q_out` after edge N equals decode(`Q_in`, `blank`) sampled at edge N.
- Throughput: a new `Q_in` is accepted on every clock. Back-to-back changes are each reflected one cycle later.
- Simultaneous `blank`=1 and a valid `Q_in` change: `blank` wins; the output is off on the next edge.
- Reset mid-operation: `Q_out` goes to off immediately. The prior value is not retained.
- Multiplexer rate: `Q_in` changes at the 500 Hz scan rate, far slower than the 1-cycle latency. No handshake is required.

## Test plan
- Reset: hold `reset_n`=0 with `Q_in`=0x8 → `Q_out`=1111111 (ACTIVE_LOW=1), including before any clock edge.
- Full sweep: `Q_in`=0x0..0xF, one per clock, with `blank`=0 → each `Q_out` matches the table one cycle later. Checks: 0x0→1000000, 0x7→1111000, 0xF→0001110.
- Blank: `Q_in`=0x3 with `blank`=1 → `Q_out`=1111111 next cycle. Deassert `blank` → `Q_out`=0110000 one cycle later.
- Async reset mid-stream: `Q_in`=0x2 settled (`Q_out`=0100100), drive `reset_n` low between edges → `Q_out`=1111111 immediately. Release → 0100100 after the first edge.
- Polarity: with ACTIVE_LOW=0, `Q_in`=0x1 → `Q_out`=0000110 and `blank`=1 → 0000000. After reset, `Q_out`=0000000.
- X input: `Q_in`=4'bxxxx, `blank`=0 → `Q_out`=1111111 (ACTIVE_LOW=1), never X.
